// File: rtl/block_row_store.sv
// Row-presence store for the blocks painter: holds the brick bitmap, serves the
// current row, applies clear-only write-backs and tracks the remaining-block count.
module block_row_store #(
  parameter int BLOCKS_PER_ROW = 13,
  parameter int NUM_ROWS       = 16,
  parameter int FILLED_ROWS    = 8,
  parameter int CNT_W          = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      level_start,
  input  logic                      new_frame,
  input  logic                      go_next_line,
  input  logic                      write_block_line_state,
  input  logic [BLOCKS_PER_ROW-1:0] new_block_line_state,
  output logic [BLOCKS_PER_ROW-1:0] block_line_state,
  output logic                      busy,
  output logic [CNT_W-1:0]          blocks_remaining,
  output logic                      hit_valid,
  output logic [3:0]                hit_count,
  output logic                      level_cleared
);

  localparam int PTR_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [PTR_W-1:0] LAST_ROW   = PTR_W'(NUM_ROWS - 1);
  localparam logic [CNT_W-1:0] INIT_COUNT = CNT_W'(FILLED_ROWS * BLOCKS_PER_ROW);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_INIT    = 2'd1,
    S_RUN     = 2'd2,
    S_CLEARED = 2'd3
  } state_t;

  state_t                    state;
  logic [BLOCKS_PER_ROW-1:0] rows [NUM_ROWS];
  logic [PTR_W-1:0]          row_ptr;
  logic [PTR_W-1:0]          init_ptr;
  logic [BLOCKS_PER_ROW-1:0] cur_row;
  logic [BLOCKS_PER_ROW-1:0] cleared_bits;
  logic [CNT_W-1:0]          removed;

  assign cur_row          = rows[row_ptr];
  assign block_line_state = cur_row;
  assign busy             = (state == S_INIT);
  assign level_cleared    = (state == S_CLEARED);

  // Only bits present in storage can be removed, so the count cannot underflow.
  always_comb begin
    cleared_bits = cur_row & ~new_block_line_state;
    removed      = '0;
    for (int i = 0; i < BLOCKS_PER_ROW; i++) begin
      removed = removed + CNT_W'(cleared_bits[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      row_ptr          <= '0;
      init_ptr         <= '0;
      blocks_remaining <= '0;
      hit_valid        <= 1'b0;
      hit_count        <= '0;
      for (int i = 0; i < NUM_ROWS; i++) begin
        rows[i] <= '0;
      end
    end else begin
      hit_valid <= 1'b0;
      if (level_start) begin
        init_ptr         <= '0;
        row_ptr          <= '0;
        blocks_remaining <= '0;
        state            <= S_INIT;
      end else if (state == S_INIT) begin
        // One row per cycle; pointer and write inputs are frozen until done.
        rows[init_ptr] <= (int'(init_ptr) < FILLED_ROWS) ? '1 : '0;
        init_ptr       <= init_ptr + PTR_W'(1);
        if (init_ptr == LAST_ROW) begin
          blocks_remaining <= INIT_COUNT;
          state            <= (FILLED_ROWS == 0) ? S_CLEARED : S_RUN;
        end
      end else begin
        if (state == S_RUN && write_block_line_state) begin
          rows[row_ptr]    <= cur_row & new_block_line_state;
          blocks_remaining <= blocks_remaining - removed;
          if (removed != '0) begin
            hit_valid <= 1'b1;
            hit_count <= removed[3:0];
          end
          if (blocks_remaining == removed) begin
            state <= S_CLEARED;
          end
        end
        // The write above targets the pre-increment row.
        if (new_frame) begin
          row_ptr <= '0;
        end else if (go_next_line) begin
          row_ptr <= (row_ptr == LAST_ROW) ? '0 : row_ptr + PTR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_block_row_store.sv
// Bench for block_row_store: directed level scenarios followed by random traffic,
// all checked against a bitmap model that derives the block count from popcounts.
module tb_block_row_store;

  localparam int BPR = 13;
  localparam int NR  = 16;
  localparam int FR  = 8;
  localparam int CW  = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           level_start;
  logic           new_frame;
  logic           go_next_line;
  logic           write_block_line_state;
  logic [BPR-1:0] new_block_line_state;
  logic [BPR-1:0] block_line_state;
  logic           busy;
  logic [CW-1:0]  blocks_remaining;
  logic           hit_valid;
  logic [3:0]     hit_count;
  logic           level_cleared;

  always #5 clk = ~clk;

  block_row_store #(
    .BLOCKS_PER_ROW(BPR),
    .NUM_ROWS      (NR),
    .FILLED_ROWS   (FR),
    .CNT_W         (CW)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .level_start           (level_start),
    .new_frame             (new_frame),
    .go_next_line          (go_next_line),
    .write_block_line_state(write_block_line_state),
    .new_block_line_state  (new_block_line_state),
    .block_line_state      (block_line_state),
    .busy                  (busy),
    .blocks_remaining      (blocks_remaining),
    .hit_valid             (hit_valid),
    .hit_count             (hit_count),
    .level_cleared         (level_cleared)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: bitmap, pointer, phase and the last reported hit.
  typedef enum int {M_IDLE, M_INIT, M_RUN, M_CLEARED} mode_t;
  logic [BPR-1:0] m_rows [NR];
  int             m_ptr;
  int             m_k;
  mode_t          m_mode;
  bit             m_hv;
  int             m_hc;

  function automatic int m_total();
    int s = 0;
    for (int i = 0; i < NR; i++) s += $countones(m_rows[i]);
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_rows[i] = '0;
    m_ptr  = 0;
    m_k    = 0;
    m_mode = M_IDLE;
    m_hv   = 1'b0;
    m_hc   = 0;
  endtask

  task automatic model_step(input bit ls, input bit nf, input bit gn, input bit wr,
                            input logic [BPR-1:0] d);
    int rem;
    m_hv = 1'b0;
    if (ls) begin
      m_mode = M_INIT;
      m_k    = 0;
      m_ptr  = 0;
    end else if (m_mode == M_INIT) begin
      m_rows[m_k] = (m_k < FR) ? {BPR{1'b1}} : '0;
      m_k++;
      if (m_k == NR) m_mode = (FR == 0) ? M_CLEARED : M_RUN;
    end else begin
      if (m_mode == M_RUN && wr) begin
        rem = $countones(m_rows[m_ptr] & ~d);
        m_rows[m_ptr] = m_rows[m_ptr] & d;
        if (rem != 0) begin
          m_hv = 1'b1;
          m_hc = rem;
        end
        if (m_total() == 0) m_mode = M_CLEARED;
      end
      if (nf) m_ptr = 0;
      else if (gn) m_ptr = (m_ptr + 1) % NR;
    end
  endtask

  task automatic check_all(input string tag);
    int exp_rem;
    exp_rem = (m_mode == M_RUN || m_mode == M_CLEARED) ? m_total() : 0;
    check_eq({tag, "/busy"}, 32'(busy), 32'(m_mode == M_INIT));
    check_eq({tag, "/cleared"}, 32'(level_cleared), 32'(m_mode == M_CLEARED));
    check_eq({tag, "/remaining"}, 32'(blocks_remaining), 32'(exp_rem));
    check_eq({tag, "/hit_valid"}, 32'(hit_valid), 32'(m_hv));
    check_eq({tag, "/hit_count"}, 32'(hit_count), 32'(m_hc));
    check_eq({tag, "/line"}, 32'(block_line_state), 32'(m_rows[m_ptr]));
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic cyc(input string tag, input bit ls, input bit nf, input bit gn,
                     input bit wr, input logic [BPR-1:0] d);
    level_start            = ls;
    new_frame              = nf;
    go_next_line           = gn;
    write_block_line_state = wr;
    new_block_line_state   = d;
    model_step(ls, nf, gn, wr, d);
    @(posedge clk);
    #1;
    level_start            = 1'b0;
    new_frame              = 1'b0;
    go_next_line           = 1'b0;
    write_block_line_state = 1'b0;
    new_block_line_state   = '0;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_all("reset");
  endtask

  task automatic start_level(input string tag);
    cyc(tag, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < NR; i++) begin
      check_eq({tag, "/busy_window"}, 32'(busy), 32'd1);
      idle(tag, 1);
    end
    check_eq({tag, "/busy_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst                    = 1'b1;
    level_start            = 1'b0;
    new_frame              = 1'b0;
    go_next_line           = 1'b0;
    write_block_line_state = 1'b0;
    new_block_line_state   = '0;

    reset_dut();
    check_eq("reset_line", 32'(block_line_state), 32'h0);

    start_level("init");
    check_eq("init_rem", 32'(blocks_remaining), 32'd104);
    check_eq("init_row0", 32'(block_line_state), 32'h1FFF);

    // First hit: three bricks cleared in row 0.
    cyc("hit3", 1'b0, 1'b0, 1'b0, 1'b1, 13'h1FF8);
    check_eq("hit3_valid", 32'(hit_valid), 32'd1);
    check_eq("hit3_count", 32'(hit_count), 32'd3);
    check_eq("hit3_rem", 32'(blocks_remaining), 32'd101);
    check_eq("hit3_line", 32'(block_line_state), 32'h1FF8);
    idle("hit3_after", 1);
    check_eq("hit3_pulse", 32'(hit_valid), 32'd0);

    // Setting bits cannot restore bricks.
    cyc("noset", 1'b0, 1'b0, 1'b0, 1'b1, 13'h1FFF);
    check_eq("noset_line", 32'(block_line_state), 32'h1FF8);
    check_eq("noset_valid", 32'(hit_valid), 32'd0);
    check_eq("noset_rem", 32'(blocks_remaining), 32'd101);

    // Full wrap of the row pointer.
    for (int i = 0; i < NR; i++) begin
      cyc("wrap", 1'b0, 1'b0, 1'b1, 1'b0, '0);
      if (i == FR - 1) check_eq("row8_empty", 32'(block_line_state), 32'h0);
    end
    check_eq("wrap_row0", 32'(block_line_state), 32'h1FF8);
    cyc("step", 1'b0, 1'b0, 1'b1, 1'b0, '0);
    cyc("nf_prio", 1'b0, 1'b1, 1'b1, 1'b0, '0);
    check_eq("nf_prio_line", 32'(block_line_state), 32'h1FF8);

    // Clear rows 0..6 with write+advance, leave one brick in row 7.
    for (int i = 0; i < FR - 1; i++) cyc("sweep", 1'b0, 1'b0, 1'b1, 1'b1, '0);
    cyc("leave1", 1'b0, 1'b0, 1'b0, 1'b1, 13'h0001);
    check_eq("leave1_rem", 32'(blocks_remaining), 32'd1);
    cyc("last", 1'b0, 1'b0, 1'b0, 1'b1, '0);
    check_eq("last_count", 32'(hit_count), 32'd1);
    check_eq("last_rem", 32'(blocks_remaining), 32'd0);
    check_eq("last_cleared", 32'(level_cleared), 32'd1);
    cyc("post_clear", 1'b0, 1'b0, 1'b1, 1'b1, '0);
    check_eq("post_clear_valid", 32'(hit_valid), 32'd0);

    // Restart, bring the count to 50, then restart mid-run with ignored traffic.
    start_level("lvl2");
    for (int i = 0; i < 4; i++) cyc("drain", 1'b0, 1'b0, 1'b1, 1'b1, '0);
    cyc("drain2", 1'b0, 1'b0, 1'b0, 1'b1, 13'h1FFC);
    check_eq("rem50", 32'(blocks_remaining), 32'd50);
    cyc("restart", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < NR; i++) cyc("init_ign", 1'b0, 1'b0, 1'b1, 1'b1, '0);
    check_eq("restart_rem", 32'(blocks_remaining), 32'd104);
    check_eq("restart_cleared", 32'(level_cleared), 32'd0);
    check_eq("restart_row0", 32'(block_line_state), 32'h1FFF);

    // Reset in the middle of initialisation.
    cyc("ls_mid", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle("init_part", 5);
    reset_dut();
    for (int i = 0; i < NR; i++) cyc("zero_walk", 1'b0, 1'b0, 1'b1, 1'b0, '0);

    // Random traffic.
    start_level("rnd_init");
    for (int n = 0; n < 2000; n++) begin
      bit ls, nf, gn, wr;
      logic [BPR-1:0] d;
      int sel;
      ls  = ($urandom_range(0, 299) == 0) || (m_mode == M_CLEARED && $urandom_range(0, 9) == 0);
      nf  = ($urandom_range(0, 15) == 0);
      gn  = ($urandom_range(0, 2) == 0);
      wr  = ($urandom_range(0, 1) == 0);
      sel = $urandom_range(0, 3);
      if (sel < 2) d = ~(BPR'(1) << $urandom_range(0, BPR - 1));
      else if (sel == 2) d = BPR'($urandom);
      else d = '1;
      cyc("rnd", ls, nf, gn, wr, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
